// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder and the blocks that consume it.
//
// ADDER_MAX_WIDTH : widest operand the adder supports.
// adder_result_t  : container for a registered adder result. The sum field is
//                   sized for the widest adder, and narrower results are
//                   zero-extended into it.
package adder_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

    typedef struct packed {
        logic                       cout;
        logic                       ovf;
        logic [ADDER_MAX_WIDTH-1:0] sum;
    } adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder. This is the building block of the ripple chain.
//
// Ports:
//   a, b : operand bits
//   cin  : carry into this bit position
//   s    : sum bit
//   co   : carry out of this bit position
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/adder.sv
// Ripple-carry adder computing {cout, sum} = a + b + cin.
// The result is available combinationally and also as a one-cycle registered
// copy with a valid strobe.
//
// Parameters:
//   WIDTH     : operand and sum width, 1..64. A width of 1 gives a plain full adder.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset. It clears the registered path only.
//   a, b, cin : operands and carry in
//   sum, cout : combinational result
//   ovf       : combinational two's-complement overflow
//   in_valid  : captures the combinational result on the next rising edge
//   sum_q, cout_q, ovf_q : registered result. It holds while in_valid is low.
//   out_valid : high for the cycle after each capture
module adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // carry[i] is the carry into bit i. carry[WIDTH] is the final carry out.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .co  (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
    // Signed overflow occurs when the carry into the MSB differs from the carry
    // out of it. For WIDTH=1 the carry into the MSB is cin itself.
    assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             out_valid_d;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch.
        // Without the defaults, a missed path would infer a latch.
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum;
            cout_d = cout;
            ovf_d  = ovf;
        end
    end

    // NOTE: the result register is reset as well as the valid bit. Consumers
    // may look at sum_q without qualifying it, so after reset it must read
    // zero and not a stale value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from values sampled before the edge.
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            out_valid <= out_valid_d;
        end
    end

endmodule : adder

// File: tb/tb_adder.sv
// Self-checking bench for adder. It instantiates WIDTH = 1, 4, 8 and 16 copies.
// It checks fixed vector tables, hand-written registered-path sequences, and
// random WIDTH=16 traffic against an arithmetic reference model.
module tb_adder;
    import adder_pkg::*;

    int tests_run = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH = 1
    logic a1, b1, cin1, sum1, cout1, ovf1, iv1, sum_q1, cout_q1, ovf_q1, ov1;
    // WIDTH = 4
    logic [3:0] a4, b4, sum4, sum_q4;
    logic cin4, cout4, ovf4, iv4, cout_q4, ovf_q4, ov4;
    // WIDTH = 8
    logic [7:0] a8, b8, sum8, sum_q8;
    logic cin8, cout8, ovf8, iv8, cout_q8, ovf_q8, ov8;
    // WIDTH = 16
    logic [15:0] a16, b16, sum16, sum_q16;
    logic cin16, cout16, ovf16, iv16, cout_q16, ovf_q16, ov16;

    adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .in_valid(iv1),
        .sum_q(sum_q1), .cout_q(cout_q1), .ovf_q(ovf_q1), .out_valid(ov1));
    adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .in_valid(iv4),
        .sum_q(sum_q4), .cout_q(cout_q4), .ovf_q(ovf_q4), .out_valid(ov4));
    adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .in_valid(iv8),
        .sum_q(sum_q8), .cout_q(cout_q8), .ovf_q(ovf_q8), .out_valid(ov8));
    adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .in_valid(iv16),
        .sum_q(sum_q16), .cout_q(cout_q16), .ovf_q(ovf_q16), .out_valid(ov16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model. It does plain integer addition for the unsigned result.
    // Overflow is a range test on the signed interpretation of the operands.
    function automatic adder_result_t ref_add(input int w, input longint unsigned a,
                                              input longint unsigned b, input bit cin);
        adder_result_t r;
        longint unsigned full;
        longint sa, sb, ss, lim;
        full   = a + b + longint'(cin);
        r      = '0;
        r.sum  = full & ((64'd1 << w) - 1);
        r.cout = ((full >> w) & 1) != 0;
        lim    = longint'(64'd1 << (w - 1));
        sa     = (a >= longint'(lim)) ? longint'(a) - 2 * lim : longint'(a);
        sb     = (b >= longint'(lim)) ? longint'(b) - 2 * lim : longint'(b);
        ss     = sa + sb + longint'(cin);
        r.ovf  = (ss > lim - 1) || (ss < -lim);
        return r;
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t v1[8];
    vec_t v4[4];
    adder_result_t model_q;
    logic          model_valid;
    adder_result_t exp_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // WIDTH=1 truth table: (sum,cout) = 00,10,10,01,10,01,01,11
        v1[0] = '{16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0};
        v1[1] = '{16'd0, 16'd0, 1'b1, 16'd1, 1'b0, 1'b1};
        v1[2] = '{16'd0, 16'd1, 1'b0, 16'd1, 1'b0, 1'b0};
        v1[3] = '{16'd0, 16'd1, 1'b1, 16'd0, 1'b1, 1'b0};
        v1[4] = '{16'd1, 16'd0, 1'b0, 16'd1, 1'b0, 1'b0};
        v1[5] = '{16'd1, 16'd0, 1'b1, 16'd0, 1'b1, 1'b0};
        v1[6] = '{16'd1, 16'd1, 1'b0, 16'd0, 1'b1, 1'b1};
        v1[7] = '{16'd1, 16'd1, 1'b1, 16'd1, 1'b1, 1'b0};
        // WIDTH=4 boundary vectors
        v4[0] = '{16'hF, 16'hF, 1'b1, 16'hF, 1'b1, 1'b0};
        v4[1] = '{16'h7, 16'h1, 1'b0, 16'h8, 1'b0, 1'b1};
        v4[2] = '{16'h8, 16'h8, 1'b0, 16'h0, 1'b1, 1'b1};
        v4[3] = '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0};

        rst_n = 1'b0;
        {a1, b1, cin1, iv1} = '0;
        {a4, b4, cin4, iv4} = '0;
        {a8, b8, cin8, iv8} = '0;
        {a16, b16, cin16, iv16} = '0;
        #1;

        check("reset_out_valid_w1", 64'(ov1), 64'd0);
        check("reset_out_valid_w8", 64'(ov8), 64'd0);
        check("reset_sum_q_w8", 64'(sum_q8), 64'd0);
        check("reset_cout_q_w4", 64'(cout_q4), 64'd0);

        // Combinational sweep. Pass 0 runs with reset held, pass 1 after release.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                a1 = v1[i].a[0]; b1 = v1[i].b[0]; cin1 = v1[i].cin;
                #1;
                check($sformatf("w1_sum_%0d_p%0d", i, pass), 64'(sum1), 64'(v1[i].sum[0]));
                check($sformatf("w1_cout_%0d_p%0d", i, pass), 64'(cout1), 64'(v1[i].cout));
                check($sformatf("w1_ovf_%0d_p%0d", i, pass), 64'(ovf1), 64'(v1[i].ovf));
            end
            for (int i = 0; i < 4; i++) begin
                a4 = v4[i].a[3:0]; b4 = v4[i].b[3:0]; cin4 = v4[i].cin;
                #1;
                check($sformatf("w4_sum_%0d_p%0d", i, pass), 64'(sum4), 64'(v4[i].sum[3:0]));
                check($sformatf("w4_cout_%0d_p%0d", i, pass), 64'(cout4), 64'(v4[i].cout));
                check($sformatf("w4_ovf_%0d_p%0d", i, pass), 64'(ovf4), 64'(v4[i].ovf));
            end
        end

        // WIDTH=1 single in_valid pulse, then hold
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; iv1 = 1'b1;
        tick();
        check("w1_pulse_out_valid", 64'(ov1), 64'd1);
        check("w1_pulse_sum_q", 64'(sum_q1), 64'd0);
        check("w1_pulse_cout_q", 64'(cout_q1), 64'd1);
        check("w1_pulse_ovf_q", 64'(ovf_q1), 64'd1);
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
        tick();
        check("w1_hold_out_valid", 64'(ov1), 64'd0);
        check("w1_hold_sum_q", 64'(sum_q1), 64'd0);
        check("w1_hold_cout_q", 64'(cout_q1), 64'd1);

        // WIDTH=8 back-to-back beats
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; iv8 = 1'b1;
        tick();
        check("w8_b2b0_valid", 64'(ov8), 64'd1);
        check("w8_b2b0_sum_q", 64'(sum_q8), 64'd30);
        check("w8_b2b0_cout_q", 64'(cout_q8), 64'd0);
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
        tick();
        check("w8_b2b1_valid", 64'(ov8), 64'd1);
        check("w8_b2b1_sum_q", 64'(sum_q8), 64'd45);
        check("w8_b2b1_cout_q", 64'(cout_q8), 64'd1);
        check("w8_b2b1_ovf_q", 64'(ovf_q8), 64'd0);
        a8 = 8'd255; b8 = 8'd0; cin8 = 1'b1;
        tick();
        check("w8_b2b2_valid", 64'(ov8), 64'd1);
        check("w8_b2b2_sum_q", 64'(sum_q8), 64'd0);
        check("w8_b2b2_cout_q", 64'(cout_q8), 64'd1);
        iv8 = 1'b0;
        tick();
        check("w8_b2b_end_valid", 64'(ov8), 64'd0);
        check("w8_b2b_end_hold", 64'(sum_q8), 64'd0);

        // Reset mid-operation with in_valid still high
        @(negedge clk);
        a8 = 8'h81; b8 = 8'h82; cin8 = 1'b0; iv8 = 1'b1;
        tick();
        check("w8_pre_reset_valid", 64'(ov8), 64'd1);
        check("w8_pre_reset_sum_q", 64'(sum_q8), 64'h03);
        check("w8_pre_reset_ovf_q", 64'(ovf_q8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("w8_async_rst_valid", 64'(ov8), 64'd0);
        check("w8_async_rst_sum_q", 64'(sum_q8), 64'd0);
        check("w8_async_rst_cout_q", 64'(cout_q8), 64'd0);
        check("w8_async_rst_ovf_q", 64'(ovf_q8), 64'd0);
        check("w8_comb_in_reset", 64'(sum8), 64'h03);
        tick();
        check("w8_rst_hold_valid", 64'(ov8), 64'd0);
        #2 rst_n = 1'b1; iv8 = 1'b0;
        tick();
        check("w8_post_rst_idle_valid", 64'(ov8), 64'd0);
        check("w8_post_rst_idle_sum_q", 64'(sum_q8), 64'd0);
        iv8 = 1'b1;
        tick();
        check("w8_post_rst_cap_valid", 64'(ov8), 64'd1);
        check("w8_post_rst_cap_sum_q", 64'(sum_q8), 64'h03);
        check("w8_post_rst_cap_cout_q", 64'(cout_q8), 64'd1);
        iv8 = 1'b0;

        // WIDTH=16 random traffic against the reference model
        model_q = '0;
        model_valid = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            check("w16_rand_valid", 64'(ov16), 64'(model_valid));
            check("w16_rand_reg", {cout_q16, ovf_q16, 46'd0, sum_q16},
                  {model_q.cout, model_q.ovf, 46'd0, model_q.sum[15:0]});
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            iv16  = ($urandom_range(3) != 0);
            if (n < 2) begin
                a16 = (n == 0) ? 16'hFFFF : 16'h0000;
                b16 = a16;
                cin16 = (n == 0);
            end
            #1;
            exp_r = ref_add(16, longint'(a16), longint'(b16), cin16);
            check("w16_rand_comb", {cout16, ovf16, 46'd0, sum16},
                  {exp_r.cout, exp_r.ovf, 46'd0, exp_r.sum[15:0]});
            model_valid = iv16;
            if (iv16) model_q = exp_r;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_adder
